// File: rtl/mem_acc_pkg.sv
// Shared definitions for the load/store sequencer in front of the 32x8 data memory.
// Covers the default widths, the request op encodings and the FSM state encoding.
package mem_acc_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LOADI = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one request at a time, absorbs the 1-cycle memory read latency.
// Define MEM_ACC_INDIRECT_EN to enable LOADI (pointer read then operand read); otherwise op 10 is reserved.
module mem_access_ctrl
    import mem_acc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] acc_in,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef MEM_ACC_INDIRECT_EN
    logic              ptr_q, ptr_d;
`endif

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
`ifdef MEM_ACC_INDIRECT_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef MEM_ACC_INDIRECT_EN
                ptr_d = 1'b0;
`endif
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = acc_in;
                    op_d    = req_op;
                    case (req_op)
                        OP_LOAD:  state_d = ST_READ;
                        OP_STORE: state_d = ST_WRITE;
`ifdef MEM_ACC_INDIRECT_EN
                        OP_LOADI: begin
                            ptr_d   = 1'b1;
                            state_d = ST_READ;
                        end
`endif
                        default: begin
                            rsp_data_d = '0;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end
            ST_READ: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
`ifdef MEM_ACC_INDIRECT_EN
                if (ptr_q) begin
                    // Pointer phase: only the low address bits of the fetched word are meaningful.
                    addr_d  = mem_rdata[ADDR_W-1:0];
                    ptr_d   = 1'b0;
                    state_d = ST_READ;
                end else begin
                    rsp_data_d = mem_rdata;
                    state_d    = ST_RESP;
                end
`else
                rsp_data_d = mem_rdata;
                state_d    = ST_RESP;
`endif
            end
            ST_WRITE: begin
                rsp_data_d = wdata_q;
                state_d    = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_LOAD;
            rsp_data_q <= '0;
`ifdef MEM_ACC_INDIRECT_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEM_ACC_INDIRECT_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Memory strobes decode from state only, so reset drops them without waiting for an edge.
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign mem_re    = (state_q == ST_READ);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = (mem_re || mem_we) ? addr_q : '0;
    assign mem_wdata = mem_we ? wdata_q : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
`ifdef MEM_ACC_INDIRECT_EN
    assign rsp_err   = rsp_valid && (op_q == OP_RSVD);
`else
    assign rsp_err   = rsp_valid && ((op_q == OP_RSVD) || (op_q == OP_LOADI));
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 32x8 registered-read memory.
// LOADI expectations follow MEM_ACC_INDIRECT_EN as compiled.
module tb_mem_access_ctrl;
    import mem_acc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [4:0] req_addr;
    logic [7:0] acc_in;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] mem_addr;
    logic       mem_re;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    logic [7:0] mem [32];

    int checks   = 0;
    int failures = 0;

    // Per-request observations filled in by do_req.
    int         lat;
    logic [7:0] r_data;
    logic       r_err;
    int         re_cnt;
    int         we_cnt;
    logic [4:0] re_addr [2];
    logic [4:0] we_addr;
    logic [7:0] we_data;
    int         ready_bad;
    logic       pulse_long;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .acc_in    (acc_in),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write, registered read that returns 0 when not enabled.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] data);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        acc_in    = data;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; r_data = 'x; r_err = 'x; re_cnt = 0; we_cnt = 0;
        we_addr = 'x; we_data = 'x; ready_bad = 0; pulse_long = 1'b0;
        re_addr[0] = 'x; re_addr[1] = 'x;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_re) begin
                if (re_cnt < 2) re_addr[re_cnt] = mem_addr;
                re_cnt++;
            end
            if (mem_we) begin
                we_addr = mem_addr;
                we_data = mem_wdata;
                we_cnt++;
            end
            if (req_ready || (busy !== ~req_ready)) ready_bad++;
            if (rsp_valid) begin
                lat    = k;
                r_data = rsp_data;
                r_err  = rsp_err;
                break;
            end
        end
        @(negedge clk);
        pulse_long = rsp_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; acc_in = '0;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mem_re, mem_we, rsp_valid, rsp_err}, 4'b0000);
        chk("rst_addr_wdata_rdata", {mem_addr, mem_wdata, rsp_data}, 21'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_strobes", {req_ready, mem_re, mem_we, rsp_valid}, 4'b1000);
    endtask

    task automatic test_store();
        do_req(OP_STORE, 5'd3, 8'hA5);
        chk("st_latency", lat, 2);
        chk("st_rsp_data", r_data, 8'hA5);
        chk("st_rsp_err", r_err, 1'b0);
        chk("st_we_cycles", we_cnt, 1);
        chk("st_we_addr", we_addr, 5'd3);
        chk("st_we_data", we_data, 8'hA5);
        chk("st_no_read", re_cnt, 0);
        chk("st_busy_while_active", ready_bad, 0);
        chk("st_single_pulse", pulse_long, 1'b0);
    endtask

    task automatic test_load();
        do_req(OP_LOAD, 5'd3, 8'h00);
        chk("ld_latency", lat, 3);
        chk("ld_rsp_data", r_data, 8'hA5);
        chk("ld_rsp_err", r_err, 1'b0);
        chk("ld_re_cycles", re_cnt, 1);
        chk("ld_re_addr", re_addr[0], 5'd3);
        chk("ld_no_write", we_cnt, 0);
        chk("ld_single_pulse", pulse_long, 1'b0);
        // Top address boundary: store then load at 31.
        do_req(OP_STORE, 5'd31, 8'h5A);
        do_req(OP_LOAD, 5'd31, 8'h00);
        chk("ld31_rsp_data", r_data, 8'h5A);
    endtask

    task automatic test_loadi();
        do_req(OP_STORE, 5'd7, 8'hE2);
        do_req(OP_STORE, 5'd2, 8'h3C);
        do_req(OP_LOADI, 5'd7, 8'h00);
`ifdef MEM_ACC_INDIRECT_EN
        chk("ldi_latency", lat, 5);
        chk("ldi_rsp_data", r_data, 8'h3C);
        chk("ldi_rsp_err", r_err, 1'b0);
        chk("ldi_re_cycles", re_cnt, 2);
        chk("ldi_ptr_addr", re_addr[0], 5'd7);
        chk("ldi_opnd_addr", re_addr[1], 5'd2);
`else
        chk("ldi_latency", lat, 1);
        chk("ldi_rsp_data", r_data, 8'h00);
        chk("ldi_rsp_err", r_err, 1'b1);
        chk("ldi_no_access", re_cnt + we_cnt, 0);
`endif
        chk("ldi_single_pulse", pulse_long, 1'b0);
    endtask

    task automatic test_reserved();
        do_req(OP_RSVD, 5'd5, 8'h77);
        chk("rsv_latency", lat, 1);
        chk("rsv_rsp_err", r_err, 1'b1);
        chk("rsv_rsp_data", r_data, 8'h00);
        chk("rsv_no_access", re_cnt + we_cnt, 0);
        chk("rsv_single_pulse", pulse_long, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LOAD; req_addr = 5'd3; acc_in = 8'h00;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("b2b_rsp_data", rsp_data, 8'hA5);
                if (pulses == 0) first = k;
                else second = k;
                pulses++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_first_rsp", first, 3);
        chk("b2b_second_rsp", second, 7);
        chk("b2b_pulses", pulses, 2);
        @(negedge clk);
        chk("b2b_idle_after", {req_ready, rsp_valid}, 2'b10);
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_STORE; req_addr = 5'd3; acc_in = 8'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rmw_in_write", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmw_we_dropped", {mem_we, mem_re}, 2'b00);
        chk("rmw_ready", {req_ready, busy}, 2'b10);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rmw_no_rsp", seen, 0);
        chk("rmw_mem_unchanged", mem[3], 8'hA5);
        do_req(OP_LOAD, 5'd3, 8'h00);
        chk("rmw_load_old", r_data, 8'hA5);
        chk("rmw_load_lat", lat, 3);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        test_reset();
        test_store();
        test_load();
        test_loadi();
        test_reserved();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
